// File: rtl/divide_int_sequencer_pkg.sv
// Shared types and sizing helpers for the integer-divide command sequencer.
package divide_int_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      RUN   = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } seq_state_t;

   localparam int unsigned DEF_WIDTH_DEND     = 32;
   localparam int unsigned DEF_WIDTH_DSOR     = 32;
   localparam int unsigned DEF_GAP_CYCLES     = 2;
   localparam int unsigned DEF_TIMEOUT_MARGIN = 8;

   // Bits needed to hold values 0..value-1 (never less than 1).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 1;
      for (int unsigned i = 1; i < 32; i++)
         if ((64'd1 << i) < 64'(value)) width = i + 1;
      return width;
   endfunction

   function automatic int unsigned timeout_w(input int unsigned width_dend,
                                             input int unsigned margin);
      return clog2(width_dend + 2 + margin + 1);
   endfunction

   function automatic int unsigned gap_w(input int unsigned gap_cycles);
      return clog2(gap_cycles + 1);
   endfunction

endpackage

// File: rtl/divide_int_sequencer_if.sv
// Request, divider-facing and result handshake signals of the divide sequencer.
interface divide_int_sequencer_if
   import divide_int_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH_DEND = DEF_WIDTH_DEND,
   parameter int unsigned WIDTH_DSOR = DEF_WIDTH_DSOR
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_sign;
   logic [WIDTH_DEND-1:0] in_dend;
   logic [WIDTH_DSOR-1:0] in_dsor;
   logic                  div_start;
   logic                  div_sign;
   logic [WIDTH_DEND-1:0] div_dend;
   logic [WIDTH_DSOR-1:0] div_dsor;
   logic                  div_done;
   logic [WIDTH_DEND-1:0] div_quot;
   logic [WIDTH_DSOR-1:0] div_rmdr;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH_DEND-1:0] out_quot;
   logic [WIDTH_DSOR-1:0] out_rmdr;
   logic                  out_dz;
   logic                  out_err;

   modport slave (
      input  in_valid, in_sign, in_dend, in_dsor, div_done, div_quot, div_rmdr, out_ready,
      output in_ready, div_start, div_sign, div_dend, div_dsor,
             out_valid, out_quot, out_rmdr, out_dz, out_err
   );

   modport master (
      output in_valid, in_sign, in_dend, in_dsor, div_done, div_quot, div_rmdr, out_ready,
      input  in_ready, div_start, div_sign, div_dend, div_dsor,
             out_valid, out_quot, out_rmdr, out_dz, out_err
   );
endinterface

// File: rtl/divide_int_sequencer_down_counter.sv
// Loadable down-counter with a zero flag; used for the RUN timeout and the GAP spacing.
module seq_down_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);
   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              count <= '0;
      else if (load)          count <= load_value;
      else if (dec && !zero)  count <= count - WIDTH'(1);
   end

   assign zero = (count == '0);
endmodule

// File: rtl/divide_int_sequencer.sv
// Command stage for the sequential divider: accepts an operation, drives the level
// start protocol, captures the result and returns it, bypassing divide-by-zero and timeouts.
module divide_int_sequencer
   import divide_int_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH_DEND     = DEF_WIDTH_DEND,
   parameter int unsigned WIDTH_DSOR     = DEF_WIDTH_DSOR,
   parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int unsigned TIMEOUT_MARGIN = DEF_TIMEOUT_MARGIN
) (
   input logic                   clk,
   input logic                   rstn,
   divide_int_sequencer_if.slave bus
);
   localparam int unsigned TO_LIMIT = WIDTH_DEND + 2 + TIMEOUT_MARGIN;
   localparam int unsigned TO_W     = timeout_w(WIDTH_DEND, TIMEOUT_MARGIN);
   localparam int unsigned GAP_W    = gap_w(GAP_CYCLES);

   seq_state_t state, state_next;
   logic       accept, dsor_zero;
   logic       to_load, to_dec, to_zero;
   logic       gap_load, gap_dec, gap_zero;

   assign accept    = (state == IDLE) && bus.in_valid;
   assign dsor_zero = (bus.in_dsor == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // Done and timeout share the last RUN cycle; done is checked first in the datapath.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = dsor_zero ? HOLD : SETUP;
         SETUP:   state_next = RUN;
         RUN:     if (bus.div_done || to_zero) state_next = HOLD;
         HOLD:    if (bus.out_ready) state_next = GAP;
         GAP:     if (gap_zero) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE) && rstn;
      bus.div_start = (state == RUN);
      bus.out_valid = (state == HOLD);
      to_load       = (state == SETUP);
      to_dec        = (state == RUN);
      gap_load      = (state == HOLD) && bus.out_ready;
      gap_dec       = (state == GAP);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.div_sign <= 1'b0;
         bus.div_dend <= '0;
         bus.div_dsor <= '0;
         bus.out_quot <= '0;
         bus.out_rmdr <= '0;
         bus.out_dz   <= 1'b0;
         bus.out_err  <= 1'b0;
      end else if (accept) begin
         bus.div_sign <= bus.in_sign;
         bus.div_dend <= bus.in_dend;
         bus.div_dsor <= bus.in_dsor;
         if (dsor_zero) begin
            bus.out_quot <= '1;
            bus.out_rmdr <= WIDTH_DSOR'(bus.in_dend);
            bus.out_dz   <= 1'b1;
            bus.out_err  <= 1'b0;
         end
      end else if (state == RUN) begin
         if (bus.div_done) begin
            bus.out_quot <= bus.div_quot;
            bus.out_rmdr <= bus.div_rmdr;
            bus.out_dz   <= 1'b0;
            bus.out_err  <= 1'b0;
         end else if (to_zero) begin
            bus.out_quot <= '0;
            bus.out_rmdr <= '0;
            bus.out_dz   <= 1'b0;
            bus.out_err  <= 1'b1;
         end
      end
   end

   // Loaded with limit-1 so RUN lasts exactly TO_LIMIT cycles before aborting.
   seq_down_counter #(.WIDTH(TO_W)) u_timeout (
      .clk        (clk),
      .rstn       (rstn),
      .load       (to_load),
      .dec        (to_dec),
      .load_value (TO_W'(TO_LIMIT - 1)),
      .zero       (to_zero)
   );

   seq_down_counter #(.WIDTH(GAP_W)) u_gap (
      .clk        (clk),
      .rstn       (rstn),
      .load       (gap_load),
      .dec        (gap_dec),
      .load_value (GAP_W'(GAP_CYCLES - 1)),
      .zero       (gap_zero)
   );
endmodule

// File: tb/tb_divide_int_sequencer.sv
// Directed bench for divide_int_sequencer with a behavioural level-start divider model.
module tb_divide_int_sequencer;
   logic clk;
   logic rstn;
   int   tests;
   int   fails;

   logic        never_done;
   logic        force_done;
   int          dlat;
   int          dcnt;
   logic        model_done;
   logic [31:0] model_quot;
   logic [31:0] model_rmdr;
   int unsigned run_cycles;

   divide_int_sequencer_if #(.WIDTH_DEND(32), .WIDTH_DSOR(32)) bus ();

   divide_int_sequencer #(
      .WIDTH_DEND     (32),
      .WIDTH_DSOR     (32),
      .GAP_CYCLES     (2),
      .TIMEOUT_MARGIN (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: done rises dlat edges after it first sees div_start, drops with it.
   always @(posedge clk) begin
      if (!bus.div_start) begin
         dcnt       <= 0;
         model_done <= 1'b0;
      end else if (!never_done) begin
         dcnt <= dcnt + 1;
         if (dcnt == dlat - 1) begin
            model_done <= 1'b1;
            if (bus.div_sign) begin
               model_quot <= $signed(bus.div_dend) / $signed(bus.div_dsor);
               model_rmdr <= $signed(bus.div_dend) % $signed(bus.div_dsor);
            end else begin
               model_quot <= bus.div_dend / bus.div_dsor;
               model_rmdr <= bus.div_dend % bus.div_dsor;
            end
         end
      end
   end

   assign bus.div_done = model_done | force_done;
   assign bus.div_quot = model_quot;
   assign bus.div_rmdr = model_rmdr;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic sign, input logic [31:0] dend, input logic [31:0] dsor);
      bus.in_valid = 1'b1;
      bus.in_sign  = sign;
      bus.in_dend  = dend;
      bus.in_dsor  = dsor;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic exp_sign);
      run_cycles = 0;
      for (int i = 0; i < 100 && !bus.out_valid; i++) begin
         step();
         if (bus.div_start) begin
            run_cycles++;
            if (exp_sign) chk({tag, "_sign_run"}, bus.div_sign, 1);
         end
      end
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_start_low_hold"}, bus.div_start, 0);
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({tag, "_valid_clr"}, bus.out_valid, 0);
      chk({tag, "_gap1_ready"}, bus.in_ready, 0);
      chk({tag, "_gap1_start"}, bus.div_start, 0);
      step();
      chk({tag, "_gap2_ready"}, bus.in_ready, 0);
      chk({tag, "_gap2_start"}, bus.div_start, 0);
      step();
      chk({tag, "_idle_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      never_done    = 1'b0;
      force_done    = 1'b0;
      dlat          = 3;
      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_dend   = '0;
      bus.in_dsor   = '0;
      bus.out_ready = 1'b0;

      step();
      step();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_div_start", bus.div_start, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_quot", bus.out_quot, 0);
      chk("rst_div_dend", bus.div_dend, 0);
      rstn = 1'b1;
      #1;
      chk("rel_in_ready", bus.in_ready, 1);
      step();

      // Unsigned 100/7
      send(1'b0, 32'd100, 32'd7);
      chk("u_setup_start", bus.div_start, 0);
      chk("u_setup_dend", bus.div_dend, 100);
      chk("u_setup_ready", bus.in_ready, 0);
      step();
      chk("u_run_start", bus.div_start, 1);
      wait_result("u", 1'b0);
      chk("u_run_cycles", run_cycles, 3);
      chk("u_quot", bus.out_quot, 14);
      chk("u_rmdr", bus.out_rmdr, 2);
      chk("u_dz", bus.out_dz, 0);
      chk("u_err", bus.out_err, 0);
      release_result("u");

      // Signed -100/7
      send(1'b1, 32'hFFFF_FF9C, 32'd7);
      chk("s_div_sign", bus.div_sign, 1);
      wait_result("s", 1'b1);
      chk("s_quot", bus.out_quot, 32'hFFFF_FFF2);
      chk("s_rmdr", bus.out_rmdr, 32'hFFFF_FFFE);
      chk("s_dz", bus.out_dz, 0);
      release_result("s");

      // Divide by zero bypass
      send(1'b0, 32'h0000_1234, 32'd0);
      chk("dz_valid", bus.out_valid, 1);
      chk("dz_quot", bus.out_quot, 32'hFFFF_FFFF);
      chk("dz_rmdr", bus.out_rmdr, 32'h0000_1234);
      chk("dz_dz", bus.out_dz, 1);
      chk("dz_err", bus.out_err, 0);
      chk("dz_start", bus.div_start, 0);
      step();
      chk("dz_start_hold", bus.div_start, 0);
      chk("dz_valid_hold", bus.out_valid, 1);
      release_result("dz");

      // Spurious done in IDLE is ignored
      force_done = 1'b1;
      step();
      step();
      force_done = 1'b0;
      chk("spur_ready", bus.in_ready, 1);
      chk("spur_valid", bus.out_valid, 0);

      // Timeout: divider never answers
      never_done = 1'b1;
      send(1'b0, 32'd50, 32'd5);
      wait_result("to", 1'b0);
      chk("to_run_cycles", run_cycles, 42);
      chk("to_err", bus.out_err, 1);
      chk("to_quot", bus.out_quot, 0);
      chk("to_rmdr", bus.out_rmdr, 0);
      chk("to_dz", bus.out_dz, 0);
      release_result("to");
      never_done = 1'b0;

      // Done in the final allowed RUN cycle wins over the timeout
      dlat = 41;
      send(1'b0, 32'd1000, 32'd33);
      wait_result("edge", 1'b0);
      chk("edge_run_cycles", run_cycles, 42);
      chk("edge_err", bus.out_err, 0);
      chk("edge_quot", bus.out_quot, 30);
      chk("edge_rmdr", bus.out_rmdr, 10);
      release_result("edge");
      dlat = 3;

      // Back-to-back with a stalled consumer
      send(1'b0, 32'd20, 32'd6);
      wait_result("bb1", 1'b0);
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_dend  = 32'd81;
      bus.in_dsor  = 32'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bb1_hold_valid", bus.out_valid, 1);
         chk("bb1_hold_quot", bus.out_quot, 3);
         chk("bb1_hold_rmdr", bus.out_rmdr, 2);
         chk("bb1_hold_ready", bus.in_ready, 0);
      end
      chk("bb1_dend_kept", bus.div_dend, 20);
      release_result("bb1");
      step();
      bus.in_valid = 1'b0;
      chk("bb2_dend", bus.div_dend, 81);
      chk("bb2_setup_start", bus.div_start, 0);
      wait_result("bb2", 1'b0);
      chk("bb2_quot", bus.out_quot, 9);
      chk("bb2_rmdr", bus.out_rmdr, 0);
      release_result("bb2");

      // Reset during RUN
      never_done = 1'b1;
      send(1'b0, 32'd100, 32'd7);
      step();
      step();
      chk("mr_start_before", bus.div_start, 1);
      rstn = 1'b0;
      #1;
      chk("mr_start_drop", bus.div_start, 0);
      chk("mr_valid", bus.out_valid, 0);
      chk("mr_quot", bus.out_quot, 0);
      chk("mr_dend", bus.div_dend, 0);
      never_done = 1'b0;
      step();
      rstn = 1'b1;
      #1;
      chk("mr_rel_ready", bus.in_ready, 1);
      step();
      chk("mr_rel_valid", bus.out_valid, 0);
      send(1'b0, 32'd9, 32'd3);
      wait_result("mr", 1'b0);
      chk("mr_quot_new", bus.out_quot, 3);
      chk("mr_rmdr_new", bus.out_rmdr, 0);
      release_result("mr");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/divide_int_sequencer.md
Name: divide_int_sequencer

Overview:
- Upstream command stage for the sequential integer divider in the DFT datapath.
- Accepts one dividend/divisor/sign operation per valid/ready handshake and drives the divider's level-style start protocol.
- Waits for the divider's done level, captures quotient and remainder into its own registers, and returns them on an output valid/ready handshake.
- Bypasses the divider for divide-by-zero and aborts on timeout, so downstream logic never hangs.

Parameters:
- WIDTH_DEND, 32, dividend and quotient width.
- WIDTH_DSOR, 32, divisor and remainder width.
- GAP_CYCLES, 2, minimum cycles div_start is held low between operations (at least 1).
- TIMEOUT_MARGIN, 8, extra cycles beyond WIDTH_DEND+2 allowed before the wait for div_done aborts.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  sequencer can accept a request
- in_sign  in  1  0 = unsigned, 1 = signed
- in_dend  in  WIDTH_DEND  dividend
- in_dsor  in  WIDTH_DSOR  divisor
- div_start  out  1  level start to the divider; high for the whole operation
- div_sign  out  1  registered sign to the divider
- div_dend  out  WIDTH_DEND  registered dividend to the divider
- div_dsor  out  WIDTH_DSOR  registered divisor to the divider
- div_done  in  1  divider result-ready level
- div_quot  in  WIDTH_DEND  divider quotient
- div_rmdr  in  WIDTH_DSOR  divider remainder
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_quot  out  WIDTH_DEND  captured quotient
- out_rmdr  out  WIDTH_DSOR  captured remainder
- out_dz  out  1  divide-by-zero flag for this result
- out_err  out  1  timeout flag for this result

Behaviour:
- Reset (asynchronous, rstn low): state = IDLE. in_ready = 1 only after reset is released. All other outputs are 0, including div_start, div_*, out_*, and the counters.
- States: IDLE, SETUP, RUN, HOLD, GAP.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register sign, dend and dsor onto div_sign, div_dend and div_dsor.
  - If in_dsor == 0, go to HOLD directly with out_quot = all ones, out_rmdr = in_dend[WIDTH_DSOR-1:0] (zero-extended if WIDTH_DSOR > WIDTH_DEND), out_dz = 1, out_err = 0. div_start stays low.
  - Otherwise go to SETUP.
- SETUP:
  - Lasts 1 cycle with div_start = 0 and operands stable, so the divider's input latch sees valid data before the start edge.
  - Go to RUN.
- RUN:
  - div_start = 1. A timeout counter increments each cycle, starting from 0.
  - On div_done = 1, capture div_quot and div_rmdr into out_quot and out_rmdr, set out_dz = 0, out_err = 0, and go to HOLD.
  - If the counter reaches WIDTH_DEND+2+TIMEOUT_MARGIN first, set out_quot = 0, out_rmdr = 0, out_err = 1, and go to HOLD.
  - div_done sampled in the same cycle as the timeout limit wins over the timeout.
- HOLD:
  - out_valid = 1; outputs are held stable.
  - div_start is dropped on entry: RUN→HOLD deasserts it next cycle. Captured values are unaffected because they are registered.
  - On out_ready, clear out_valid and go to GAP.
  - in_ready = 0.
- GAP:
  - div_start = 0 for GAP_CYCLES cycles (counter), then go to IDLE.
  - This guarantees a fresh rising edge for the next operation.
  - Divide-by-zero results also pass through GAP, keeping throughput uniform.
- Operand registers div_* stay unchanged from acceptance until the next acceptance.
- The block accepts no new request outside IDLE, so there are no simultaneous accept/complete events.
- div_done is ignored in every state except RUN. A spurious div_done while in IDLE or GAP has no effect.
- Signed divide-by-zero uses the same bypass values (all-ones quotient, dividend as remainder); no sign correction is applied.
- Latency, accept to out_valid: 1 (SETUP) + 1 (first RUN cycle) + the divider's done latency + 1 capture cycle.
- Divide-by-zero latency: out_valid asserts 1 cycle after accept.
- Reset mid-operation: everything returns to reset values immediately and div_start drops asynchronously. Any in-flight result is lost and no out_valid is produced.

Decomposition:
- Shared package:
  - state encoding enum (IDLE/SETUP/RUN/HOLD/GAP, 3 bits)
  - TIMEOUT_W = clog2(WIDTH_DEND+2+TIMEOUT_MARGIN+1)
  - GAP_W
  - the common clog2 function already used across the DFT blocks
- One natural sub-module, seq_down_counter: loadable down-counter with a zero flag. It is instantiated twice, once for the timeout and once for the gap.

Test Plan:
- Unsigned 100/7 with a compliant divider model: div_start rises exactly 2 cycles after accept, then out_valid with quot = 14, rmdr = 2, out_dz = 0, out_err = 0.
- Signed -100/7: out_quot = -14 (0xFFFFFFF2), out_rmdr = -2 (0xFFFFFFFE); div_sign = 1 is held throughout RUN.
- Divisor 0, dend = 0x1234: out_valid 1 cycle after accept, quot = 0xFFFFFFFF, rmdr = 0x1234, out_dz = 1; div_start never rises.
- Divider model that never asserts div_done: out_err = 1 after exactly WIDTH_DEND+2+TIMEOUT_MARGIN RUN cycles (42 at defaults), with quot = rmdr = 0.
- Back-to-back requests with out_ready held low for 5 cycles: the result stays stable and in_ready = 0. After the handshake, div_start stays low for exactly GAP_CYCLES cycles and the second request is accepted in IDLE.
- rstn pulsed low during RUN: div_start drops in the same cycle and out_valid = 0. After release in_ready = 1 and a new 9/3 returns quot = 3, rmdr = 0.
